// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder feeding a small output FIFO; each word is tagged with a target address.
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their instruction format.
module instr_encoder #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 2,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            op,
   input  logic [2:0]            func,
   input  logic                  alt,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [4:0]            rd,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic                  addr_load,
   input  logic [DATA_WIDTH-1:0] addr_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_addr,
   output logic                  out_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_BAD = 3'd6;

   logic [2:0]            fmt;
   logic [31:0]           enc;
   logic                  enc_err;
   logic [DATA_WIDTH-1:0] tag_addr;
   logic [DATA_WIDTH-1:0] addr_cnt;

   logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
   logic [DATA_WIDTH-1:0] mem_addr  [DEPTH];
   logic                  mem_err   [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  push;
   logic                  pop;

   always_comb begin
      fmt = FMT_BAD;
      case (op)
         OP_R:                      fmt = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
         OP_STORE:                  fmt = FMT_S;
         OP_BR:                     fmt = FMT_B;
         OP_LUI, OP_AUIPC:          fmt = FMT_U;
         OP_JAL:                    fmt = FMT_J;
         default:                   fmt = FMT_BAD;
      endcase
   end

   always_comb begin
      enc = '0;
      case (fmt)
         FMT_R: enc = {1'b0, alt, 5'b00000, rs2, rs1, func, rd, op};
         FMT_I: enc = {imm[11:0], rs1, func, rd, op};
         FMT_S: enc = {imm[11:5], rs2, rs1, func, imm[4:0], op};
         FMT_B: enc = {imm[12], imm[10:5], rs2, rs1, func, imm[4:1], imm[11], op};
         FMT_U: enc = {imm[31:12], rd, op};
         FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: enc = '0;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // An immediate fits when every bit above its sign bit matches the sign bit.
   logic imm_bad;
   always_comb begin
      imm_bad = 1'b0;
      case (fmt)
         FMT_I, FMT_S: imm_bad = !((imm[DATA_WIDTH-1:11] == '0) || (imm[DATA_WIDTH-1:11] == '1));
         FMT_B:        imm_bad = !((imm[DATA_WIDTH-1:12] == '0) || (imm[DATA_WIDTH-1:12] == '1)) || imm[0];
         FMT_J:        imm_bad = !((imm[DATA_WIDTH-1:20] == '0) || (imm[DATA_WIDTH-1:20] == '1)) || imm[0];
         FMT_U:        imm_bad = (imm[11:0] != 12'h000);
         default:      imm_bad = 1'b0;
      endcase
   end
   assign enc_err = (fmt == FMT_BAD) || imm_bad;
`else
   assign enc_err = (fmt == FMT_BAD);
`endif

   assign full     = (count == CNT_W'(DEPTH));
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = out_valid && out_ready;
   assign tag_addr = addr_load ? addr_in : addr_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         addr_cnt <= BASE_ADDR;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            addr_cnt <= tag_addr + DATA_WIDTH'(4);
         end else if (addr_load) begin
            addr_cnt <= addr_in;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_instr[wr_ptr] <= DATA_WIDTH'(enc);
         mem_addr[wr_ptr]  <= tag_addr;
         mem_err[wr_ptr]   <= enc_err;
      end
   end

   assign out_valid = (count != '0);
   assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
   assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;
   assign out_err   = out_valid ? mem_err[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field bundles in, queued expected words checked by a monitor.
module tb_instr_encoder;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  op;
   logic [2:0]  func;
   logic        alt;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        addr_load;
   logic [31:0] addr_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] model_addr;

`ifdef IMM_RANGE_CHECK_EN
   localparam logic RANGE_ERR = 1'b1;
`else
   localparam logic RANGE_ERR = 1'b0;
`endif

   instr_encoder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .func(func), .alt(alt), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .addr_load(addr_load), .addr_in(addr_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs are driven just after the rising edge; accept is judged from in_ready sampled at the falling edge.
   task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f, input logic a,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                input logic [31:0] im, input logic ld, input logic [31:0] ain,
                                input logic [31:0] exp_instr, input logic exp_err);
      logic acc;
      logic [31:0] tag;
      acc = 1'b0;
      op = o; func = f; alt = a; rs1 = s1; rs2 = s2; rd = d; imm = im;
      addr_load = ld; addr_in = ain; in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (acc) begin
         tag = ld ? ain : model_addr;
         model_addr = tag + 32'd4;
         sb.push_back('{instr: exp_instr, addr: tag, err: exp_err});
      end else begin
         checkOutput("accept_timeout", 64'd0, 64'd1);
      end
      in_valid = 1'b0;
      addr_load = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, 64'(sb.size()), 64'd0);
   endtask

   // Monitor: compares the head word whenever a pop will happen, and checks stability under stall.
   initial begin
      exp_t e;
      logic stalled;
      logic [31:0] prev_instr, prev_addr;
      logic prev_err;
      stalled = 1'b0;
      prev_instr = '0; prev_addr = '0; prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid) begin
               checkOutput("stall_hold", {out_instr, out_addr}, {prev_instr, prev_addr});
               checkOutput("stall_err_hold", 64'(out_err), 64'(prev_err));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_word", {out_instr, out_addr}, 64'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("word_instr", 64'(out_instr), 64'(e.instr));
                  checkOutput("word_addr", 64'(out_addr), 64'(e.addr));
                  checkOutput("word_err", 64'(out_err), 64'(e.err));
               end
            end
            stalled = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_addr = out_addr;
            prev_err = out_err;
         end
      end
   end

   initial begin
      int accepted;
      logic acc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_in = '0;
      op = '0; func = '0; alt = 1'b0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
      model_addr = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_outs", {out_instr, out_addr}, 64'd0);
      checkOutput("reset_err", 64'(out_err), 64'd0);
      @(posedge clk);
      #1;

      // ADDI x1,x0,5 must appear in the cycle right after its accept.
      applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, 32'h0, 32'h00500093, 1'b0);
      @(negedge clk);
      checkOutput("latency_one", 64'(out_valid), 64'd1);
      waitDrain("drain_addi");

      applyStimulus(7'b0110011, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h402081B3, 1'b0);
      applyStimulus(7'b0100011, 3'd2, 1'b1, 5'd1, 5'd2, 5'd9, 32'd12, 1'b0, 32'h0, 32'h0020A623, 1'b0);
      applyStimulus(7'b1100011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, 32'h0, 32'h00208463, 1'b0);
      applyStimulus(7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0, 32'h0, 32'h123452B7, 1'b0);
      applyStimulus(7'b1101111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b0, 32'h0, 32'h001000EF, 1'b0);
      applyStimulus(7'b0000011, 3'd2, 1'b0, 5'd2, 5'd0, 5'd5, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFC12283, 1'b0);
      applyStimulus(7'b1100111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0, 32'h00008067, 1'b0);
      applyStimulus(7'b1100011, 3'd1, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFE009EE3, 1'b0);
      applyStimulus(7'b1111111, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0, 32'h0, 32'h00000000, 1'b1);
      applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd4096, 1'b0, 32'h0, 32'h00000093, RANGE_ERR);
      applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, 1'b0, 32'h0, 32'h80000093, 1'b0);
      waitDrain("drain_formats");

      // Address load on the same cycle as an accept, then wrap past the top of the address space.
      applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 32'hFFFF_FFFC, 32'h00500093, 1'b0);
      applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, 32'h0, 32'h00500093, 1'b0);
      waitDrain("drain_wrap");

      // Load without an accept, then the next word takes the loaded address.
      addr_load = 1'b1; addr_in = 32'h0000_0100;
      @(posedge clk);
      #1 addr_load = 1'b0;
      model_addr = 32'h0000_0100;
      applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, 32'h0, 32'h00500093, 1'b0);
      waitDrain("drain_load");

      // Backpressure: with the consumer stalled only DEPTH words may enter.
      out_ready = 1'b0;
      accepted = 0;
      op = 7'b0010011; func = 3'd0; alt = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd1; imm = 32'd5;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sb.push_back('{instr: 32'h00500093, addr: model_addr, err: 1'b0});
            model_addr = model_addr + 32'd4;
            accepted++;
         end
      end
      in_valid = 1'b0;
      checkOutput("bp_accepted", 64'(accepted), 64'(DEPTH));
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      waitDrain("drain_bp");

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
